// File: rtl/fp_add_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_arbiter_pkg
// Description : Shared types and constants for the two-requester FP adder
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_add_arbiter_pkg;

  localparam int C_FP_W    = 32;
  localparam int C_N_REQ   = 2;
  localparam int C_STATE_W = 2;

  localparam logic [C_STATE_W-1:0] C_ST_IDLE = 2'd0;
  localparam logic [C_STATE_W-1:0] C_ST_CALC = 2'd1;
  localparam logic [C_STATE_W-1:0] C_ST_RESP = 2'd2;

  typedef enum logic [C_STATE_W-1:0] {
    ST_IDLE = C_ST_IDLE,
    ST_CALC = C_ST_CALC,
    ST_RESP = C_ST_RESP
  } state_t;

  // One-hot select for a 1-bit requester index.
  function automatic logic [C_N_REQ-1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_arbiter_fp_add.sv
`default_nettype none
// ============================================================================
// Module      : fp_add
// Description : Combinational IEEE-754 adder for same-sign operands with
//               round-to-nearest-even; subnormal, infinity and NaN aware.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add
  import fp_add_arbiter_pkg::*;
#(
  parameter int EXP = 8,
  parameter int MTS = 23
) (
  input  logic [EXP+MTS:0] i_a,
  input  logic [EXP+MTS:0] i_b,
  output logic [EXP+MTS:0] o_sum
);

  // hidden bit + fraction + guard/round/sticky
  localparam int              W         = MTS + 4;
  localparam logic [EXP-1:0] C_EXP_MAX = '1;

  logic [EXP+MTS:0]   w_x;
  logic [EXP+MTS:0]   w_y;
  logic [EXP-1:0]     w_ex;
  logic [EXP-1:0]     w_ey;
  logic               w_x_den;
  logic               w_y_den;
  logic [EXP-1:0]     w_d;
  logic [EXP-1:0]     w_d_sat;
  logic [W-1:0]       w_mx;
  logic [W-1:0]       w_my;
  logic [2*W-1:0]     w_shift;
  logic [W-1:0]       w_y_al;
  logic [W:0]         w_add;
  logic [W-1:0]       w_m;
  logic [EXP:0]       w_e;
  logic               w_up;
  logic [EXP+MTS-1:0] w_rnd;
  logic               w_unused_y_sign;

  // The smaller operand's sign has no effect on a same-sign sum.
  assign w_unused_y_sign = w_y[EXP+MTS];

  always_comb begin
    if (i_a[EXP+MTS-1:0] >= i_b[EXP+MTS-1:0]) begin
      w_x = i_a;
      w_y = i_b;
    end else begin
      w_x = i_b;
      w_y = i_a;
    end
    w_ex    = w_x[EXP+MTS-1:MTS];
    w_ey    = w_y[EXP+MTS-1:MTS];
    w_x_den = (w_ex == '0);
    w_y_den = (w_ey == '0);
    w_d     = (w_x_den ? EXP'(1) : w_ex) - (w_y_den ? EXP'(1) : w_ey);
    w_d_sat = (w_d > EXP'(W)) ? EXP'(W) : w_d;

    w_mx    = {~w_x_den, w_x[MTS-1:0], 3'b000};
    w_my    = {~w_y_den, w_y[MTS-1:0], 3'b000};
    w_shift = {w_my, {W{1'b0}}} >> w_d_sat;
    w_y_al  = w_shift[2*W-1:W] | {{(W-1){1'b0}}, |w_shift[W-1:0]};
    w_add   = {1'b0, w_mx} + {1'b0, w_y_al};

    // A subnormal larger operand can only become normal, never carry out.
    if (w_add[W]) begin
      w_m = {w_add[W:2], w_add[1] | w_add[0]};
      w_e = {1'b0, w_ex} + (EXP+1)'(1);
    end else begin
      w_m = w_add[W-1:0];
      w_e = {1'b0, w_x_den ? {{(EXP-1){1'b0}}, w_add[W-1]} : w_ex};
    end

    // Rounding carry ripples into the exponent field naturally.
    w_up  = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_rnd = {w_e[EXP-1:0], w_m[W-2:3]} + {{(EXP+MTS-1){1'b0}}, w_up};

    o_sum = {w_x[EXP+MTS], w_rnd};
    if (w_ex == C_EXP_MAX) begin
      o_sum = {w_x[EXP+MTS], C_EXP_MAX,
               w_x[MTS-1] | (|w_x[MTS-2:0]), w_x[MTS-2:0]};
    end else if (w_e >= {1'b0, C_EXP_MAX}) begin
      o_sum = {w_x[EXP+MTS], C_EXP_MAX, {MTS{1'b0}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant2
// Description : Combinational two-way round-robin grant; the rr input names
//               the requester that currently holds priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2
  import fp_add_arbiter_pkg::*;
(
  input  logic [C_N_REQ-1:0] i_req_valid,
  input  logic               i_rr,
  output logic [C_N_REQ-1:0] o_grant,
  output logic               o_grant_idx
);

  always_comb begin
    o_grant_idx = i_req_valid[i_rr] ? i_rr : ~i_rr;
    o_grant     = (|i_req_valid) ? onehot2(o_grant_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_arbiter
// Description : Round-robin scheduler time-sharing one registered FP adder
//               between two valid/ready requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int EXP_IEEE754 = 8,
  parameter int MTS_IEEE754 = 23,
  parameter int N_REQ       = C_N_REQ,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*C_FP_W-1:0]   req_a,
  input  logic [N_REQ*C_FP_W-1:0]   req_b,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [C_FP_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr;
  logic                r_owner;
  logic [C_FP_W-1:0]   r_a;
  logic [C_FP_W-1:0]   r_b;
  logic [C_FP_W-1:0]   r_res;
  logic [CNT_W-1:0]    r_op_count;
  logic [C_FP_W-1:0]   w_sum;
  logic [N_REQ-1:0]    w_grant;
  logic                w_grant_idx;
  logic                w_req_fire;
  logic                w_rsp_fire;
  logic [C_FP_W-1:0]   w_a_slice [N_REQ];
  logic [C_FP_W-1:0]   w_b_slice [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign w_a_slice[gi] = req_a[gi*C_FP_W +: C_FP_W];
    assign w_b_slice[gi] = req_b[gi*C_FP_W +: C_FP_W];
  end

  rr_grant2 u_rr_grant (
    .i_req_valid (req_valid),
    .i_rr        (r_rr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  fp_add #(
    .EXP (EXP_IEEE754),
    .MTS (MTS_IEEE754)
  ) u_fp_add (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    w_req_fire  = 1'b0;
    w_rsp_fire  = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        req_ready  = w_grant;
        w_req_fire = |(req_valid & w_grant);
        if (w_req_fire) w_state_nxt = ST_CALC;
      end
      ST_CALC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid  = onehot2(r_owner);
        w_rsp_fire = rsp_ready[r_owner];
        if (w_rsp_fire) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Priority only moves on a completed response, so a discarded op keeps rr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr       <= 1'b0;
      r_owner    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_req_fire) begin
        r_a     <= w_a_slice[w_grant_idx];
        r_b     <= w_b_slice[w_grant_idx];
        r_owner <= w_grant_idx;
      end
      if (r_state == ST_CALC) r_res <= w_sum;
      if (w_rsp_fire) begin
        r_op_count <= r_op_count + CNT_W'(1);
        r_rr       <= ~r_owner;
      end
    end
  end

  assign rsp_data = r_res;
  assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_arbiter
// Description : Directed and randomized self-checking bench for
//               fp_add_arbiter with a real-arithmetic reference adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [63:0]   req_a;
  logic [63:0]   req_b;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [31:0]   rsp_data;
  logic          busy;
  logic [CW-1:0] op_count;

  int n_run  = 0;
  int n_fail = 0;
  int prio   = 0;   // requester with priority in the reference model
  int n_done = 0;   // completed responses since the last reset

  fp_add_arbiter #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Normal single -> double, exact.
  function automatic logic [63:0] to_dbl(input logic [31:0] f);
    if (f[30:0] == 31'd0) return 64'd0;
    return {1'b0, 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
  endfunction

  // Sum in double precision (exact for the operand ranges used), then
  // round-to-nearest-even down to single.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    real         rs;
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] m24;
    logic        up;
    int          se;
    rs = $bitstoreal(to_dbl(a)) + $bitstoreal(to_dbl(b));
    d  = $realtobits(rs);
    if (d[62:0] == 63'd0) return 32'd0;
    m   = {1'b1, d[51:0]};
    m24 = {1'b0, m[52:29]};
    up  = m[28] & ((|m[27:0]) | m[29]);
    m24 = m24 + 25'(up);
    se  = int'(d[62:52]) - 1023 + 127;
    if (m24[24]) begin
      se++;
      m24 = m24 >> 1;
    end
    return {1'b0, 8'(se), m24[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'b0, 8'($urandom_range(140, 112)), 23'($urandom)};
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    check("rst_ctrl", 32'({req_ready, rsp_valid, busy, op_count}), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    rst    = 1'b0;
    prio   = 0;
    n_done = 0;
    #1;
  endtask

  // One full transaction: grant, 2-cycle latency, optional backpressure.
  task automatic run_op(input logic [1:0] vld,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] e0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e1,
                        input int stall);
    int          g;
    int          cyc;
    logic [1:0]  gnt;
    logic [31:0] exp_sum;
    g       = vld[prio] ? prio : 1 - prio;
    gnt     = (g == 0) ? 2'b01 : 2'b10;
    exp_sum = (g == 0) ? e0 : e1;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_valid = vld;
    rsp_ready = 2'b00;
    #1;
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 8) begin
      tick();
      cyc++;
    end
    check("grant", 32'(req_ready), 32'(gnt));
    tick();
    req_valid[g] = 1'b0;
    #1;
    check("calc_ctrl", 32'({busy, rsp_valid, req_ready}), 32'(5'b10000));
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'(gnt));
    check("rsp_data", rsp_data, exp_sum);
    for (int i = 0; i < stall; i++) begin
      rsp_ready = ~gnt;
      tick();
      check("stall_ctrl", 32'({busy, rsp_valid, req_ready}), 32'({1'b1, gnt, 2'b00}));
      check("stall_data", rsp_data, exp_sum);
    end
    rsp_ready = gnt;
    tick();
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    #1;
    n_done++;
    prio = 1 - g;
    check("op_count", 32'(op_count), 32'(n_done % (1 << CW)));
    check("idle_ctrl", 32'({busy, rsp_valid}), 32'd0);
  endtask

  initial begin
    logic [31:0] ra0, rb0, ra1, rb1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = 64'd0;
    req_b     = 64'd0;
    do_reset();

    run_op(2'b01, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'd0, 32'd0, 32'd0, 0);

    do_reset();
    run_op(2'b11, 32'h3FC00000, 32'h3FE00000, 32'h40500000,
                  32'h41080000, 32'h3F400000, 32'h41140000, 0);
    run_op(2'b11, 32'h3FC00000, 32'h3FE00000, 32'h40500000,
                  32'h41080000, 32'h3F400000, 32'h41140000, 0);

    for (int k = 0; k < 6; k++)
      run_op(2'b11, 32'h40600000, 32'h3FC00000, 32'h40A00000,
                    32'h40600000, 32'h3FC00000, 32'h40A00000, 0);

    run_op(2'b10, 32'd0, 32'd0, 32'd0, 32'h40400000, 32'h40800000, 32'h40E00000, 5);

    for (int k = 0; k < 24; k++) begin
      ra0 = rand_fp(); rb0 = rand_fp();
      ra1 = rand_fp(); rb1 = rand_fp();
      run_op(2'($urandom_range(3, 1)), ra0, rb0, ref_add(ra0, rb0),
             ra1, rb1, ref_add(ra1, rb1), int'($urandom_range(3, 0)));
    end

    // Withdrawn request leaves the arbiter idle.
    req_a     = 64'h3F800000_3F800000;
    req_b     = 64'h3F800000_3F800000;
    req_valid = 2'b01;
    #1;
    check("withdraw_ready", 32'(req_ready), 32'(2'b01));
    #2;
    req_valid = 2'b00;
    tick();
    check("withdraw_idle", 32'(busy), 32'd0);

    // Leave priority with requester 1 and a non-zero count, then reset in CALC.
    do begin
      run_op(2'b01, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'd0, 32'd0, 32'd0, 0);
    end while (n_done % (1 << CW) == 0);
    req_a     = 64'h40400000_3F800000;
    req_b     = 64'h40800000_3F800000;
    req_valid = 2'b11;
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'(2'b10));
    tick();
    req_valid = 2'b00;
    rst       = 1'b1;
    #1;
    check("async_rst", 32'({busy, rsp_valid, op_count}), 32'd0);
    tick();
    rst    = 1'b0;
    prio   = 0;
    n_done = 0;
    #1;
    run_op(2'b11, 32'h3FC00000, 32'h3FE00000, 32'h40500000,
                  32'h41080000, 32'h3F400000, 32'h41140000, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
